// File: rtl/tcdm_bank_adapter.sv
// Purpose: adapts a valid/ready TCDM request port with IDs to a req/gnt bank shim with
//          fixed one-cycle read latency, returning responses in order through a credit-checked FIFO.
// Latency: accept to rsp_valid_o is 2 cycles (1 cycle with TCDM_BANK_ADAPTER_BYPASS_EN defined).
// Backpressure: requests are refused unless a response slot is guaranteed; gnt low stalls acceptance only.
// Ports: req_* upstream request channel, rsp_* response channel, bank_* shim interface.
// Optional macro TCDM_BANK_ADAPTER_BYPASS_EN: an empty FIFO forwards bank_rdata_i straight to rsp_*.
module tcdm_bank_adapter #(
    parameter int AddrMemWidth = 32,
    parameter int DataWidth    = 64,
    parameter int IdWidth      = 4,
    parameter int RspDepth     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [AddrMemWidth-1:0]   req_addr_i,
    input  logic [3:0]                req_amo_i,
    input  logic                      req_wen_i,
    input  logic [DataWidth-1:0]      req_wdata_i,
    input  logic [DataWidth/8-1:0]    req_be_i,
    input  logic [IdWidth-1:0]        req_id_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DataWidth-1:0]      rsp_rdata_o,
    output logic [IdWidth-1:0]        rsp_id_o,
    output logic                      bank_req_o,
    input  logic                      bank_gnt_i,
    output logic [AddrMemWidth-1:0]   bank_add_o,
    output logic [3:0]                bank_amo_o,
    output logic                      bank_wen_o,
    output logic [DataWidth-1:0]      bank_wdata_o,
    output logic [DataWidth/8-1:0]    bank_be_o,
    input  logic [DataWidth-1:0]      bank_rdata_i
);

    localparam int PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int CntW = $clog2(RspDepth + 1);
    localparam int SumW = CntW + 1;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   id;
    } rsp_t;

    rsp_t               mem_q [RspDepth];
    rsp_t               mem_d [RspDepth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               inflight_q, inflight_d;
    logic [IdWidth-1:0] inflight_id_q, inflight_id_d;

    logic fifo_nonempty;
    logic rsp_vld;
    logic pop;
    logic fifo_push;
    logic fifo_pop;
    logic credit_ok;
    logic accept;
    rsp_t head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Response side: FIFO head, or the bank data directly when bypass applies.
    always_comb begin
        fifo_nonempty = (count_q != '0);
        head          = mem_q[rd_ptr_q];
`ifdef TCDM_BANK_ADAPTER_BYPASS_EN
        rsp_vld     = fifo_nonempty | inflight_q;
        rsp_rdata_o = fifo_nonempty ? head.rdata : bank_rdata_i;
        rsp_id_o    = fifo_nonempty ? head.id    : inflight_id_q;
        pop         = rsp_vld & rsp_ready_i;
        // A bypassed beat consumed this cycle never enters the FIFO.
        fifo_push   = inflight_q & ~(~fifo_nonempty & rsp_ready_i);
`else
        rsp_vld     = fifo_nonempty;
        rsp_rdata_o = head.rdata;
        rsp_id_o    = head.id;
        pop         = rsp_vld & rsp_ready_i;
        fifo_push   = inflight_q;
`endif
        fifo_pop    = pop & fifo_nonempty;
    end

    assign rsp_valid_o = rsp_vld;

    // count + inflight - pop < RspDepth, rearranged to avoid underflow.
    assign credit_ok   = ({1'b0, count_q} + SumW'(inflight_q)) < (SumW'(RspDepth) + SumW'(pop));
    assign bank_req_o  = req_valid_i & credit_ok;
    assign req_ready_o = bank_gnt_i & credit_ok;
    assign accept      = req_valid_i & req_ready_o;

    assign bank_add_o   = req_addr_i;
    assign bank_amo_o   = req_amo_i;
    assign bank_wen_o   = req_wen_i;
    assign bank_wdata_o = req_wdata_i;
    assign bank_be_o    = req_be_i;

    always_comb begin
        inflight_d    = accept;
        inflight_id_d = accept ? req_id_i : inflight_id_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (fifo_push) begin
            mem_d[wr_ptr_q] = '{rdata: bank_rdata_i, id: inflight_id_q};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RspDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
        end
    end

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Bench for tcdm_bank_adapter: directed requests against a behavioural bank shim,
// expected responses queued at accept time and checked by an independent response monitor.
module tb_tcdm_bank_adapter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int RD = 2;
`ifdef TCDM_BANK_ADAPTER_BYPASS_EN
    localparam int ExpLat = 1;
`else
    localparam int ExpLat = 2;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i;
    logic [3:0]      req_amo_i;
    logic            req_wen_i;
    logic [DW-1:0]   req_wdata_i;
    logic [DW/8-1:0] req_be_i;
    logic [IW-1:0]   req_id_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [DW-1:0]   rsp_rdata_o;
    logic [IW-1:0]   rsp_id_o;
    logic            bank_req_o;
    logic            bank_gnt_i;
    logic [AW-1:0]   bank_add_o;
    logic [3:0]      bank_amo_o;
    logic            bank_wen_o;
    logic [DW-1:0]   bank_wdata_o;
    logic [DW/8-1:0] bank_be_o;
    logic [DW-1:0]   bank_rdata_i = '0;

    always #5 clk = ~clk;

    tcdm_bank_adapter #(
        .AddrMemWidth(AW), .DataWidth(DW), .IdWidth(IW), .RspDepth(RD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_amo_i(req_amo_i), .req_wen_i(req_wen_i),
        .req_wdata_i(req_wdata_i), .req_be_i(req_be_i), .req_id_i(req_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_id_o(rsp_id_o),
        .bank_req_o(bank_req_o), .bank_gnt_i(bank_gnt_i), .bank_add_o(bank_add_o),
        .bank_amo_o(bank_amo_o), .bank_wen_o(bank_wen_o), .bank_wdata_o(bank_wdata_o),
        .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
    );

    // Bank shim model: one-cycle read latency, grant withdrawn in the AMO commit cycle.
    logic [DW-1:0] shim_mem [0:255];
    logic          amo_commit_q = 1'b0;
    logic [DW-1:0] old_v;
    assign bank_gnt_i = ~amo_commit_q;

    always @(posedge clk) begin
        amo_commit_q <= 1'b0;
        if (bank_req_o && bank_gnt_i) begin
            old_v = shim_mem[bank_add_o[7:0]];
            bank_rdata_i <= old_v;
            if (bank_amo_o == 4'd2) begin
                shim_mem[bank_add_o[7:0]] <= old_v + bank_wdata_o;
                amo_commit_q <= 1'b1;
            end else if (bank_amo_o != 4'd0) begin
                shim_mem[bank_add_o[7:0]] <= bank_wdata_o;
                amo_commit_q <= 1'b1;
            end else if (bank_wen_o) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (bank_be_o[b]) shim_mem[bank_add_o[7:0]][b*8 +: 8] <= bank_wdata_o[b*8 +: 8];
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        bit            chk_data;
        bit            chk_lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d with empty scoreboard, expected no response", rsp_id_o);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", 64'(rsp_id_o), 64'(mon_e.id));
                if (mon_e.chk_data) check("rsp_rdata", rsp_rdata_o, mon_e.data);
                if (mon_e.chk_lat)  check("rsp_latency", 64'(cyc - mon_e.acc), 64'(ExpLat));
            end
        end
    end

    // Response FIFO must never be written while full.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && dut.fifo_push) begin
            checks++;
            if (!dut.fifo_pop && int'(dut.count_q) == RD) begin
                errors++;
                $display("FAIL fifo_overflow: push with count %0d, expected count below %0d", dut.count_q, RD);
            end
        end
    end

    // Drives a request (called just after a rising edge) and holds it until accepted.
    task automatic issue(input logic [AW-1:0] addr, input logic [3:0] amo, input logic wen,
                         input logic [DW-1:0] wdata, input logic [DW/8-1:0] be, input logic [IW-1:0] id,
                         input logic [DW-1:0] exp_data, input bit chk_data, input bit chk_lat,
                         output int acc_cyc);
        exp_t e;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_amo_i   = amo;
        req_wen_i   = wen;
        req_wdata_i = wdata;
        req_be_i    = be;
        req_id_i    = id;
        acc_cyc     = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc_cyc    = cyc;
                e.id       = id;
                e.data     = exp_data;
                e.chk_data = chk_data;
                e.chk_lat  = chk_lat;
                e.acc      = cyc;
                sb.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: id %0d not accepted, expected accept within 50 cycles", id);
        end
    endtask

    task automatic idle(input int n);
        req_valid_i = 1'b0;
        req_amo_i   = 4'd0;
        req_wen_i   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int a0, a1, start, rel, stall_acc, w;
    int acc8 [8];

    initial begin
        for (int i = 0; i < 256; i++) shim_mem[i] = '0;
        shim_mem[8'h10] = 64'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) shim_mem[8'h20 + i] = 64'h1000 + 64'(i);
        shim_mem[8'h40] = 64'd100;

        rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_amo_i = '0; req_wen_i = 1'b0;
        req_wdata_i = '0; req_be_i = '0; req_id_i = '0; rsp_ready_i = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_bank_req", 64'(bank_req_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;

        // Single load, ready in the same cycle it is offered
        start = cyc;
        issue(32'h10, 4'd0, 1'b0, '0, 8'hFF, 4'd3, 64'hDEAD_BEEF, 1'b1, 1'b1, a0);
        check("single_ready_at_t", 64'(a0), 64'(start));
        idle(4);

        // Eight back-to-back loads
        for (int i = 0; i < 8; i++) begin
            issue(32'h20 + 32'(i), 4'd0, 1'b0, '0, 8'hFF, 4'(i), 64'h1000 + 64'(i), 1'b1, 1'b1, acc8[i]);
        end
        check("b2b_span", 64'(acc8[7] - acc8[0]), 64'd7);
        idle(4);

        // AMO add then load to the same word
        issue(32'h40, 4'd2, 1'b0, 64'd5, 8'hFF, 4'd1, 64'd100, 1'b1, 1'b1, a0);
        issue(32'h40, 4'd0, 1'b0, '0, 8'hFF, 4'd2, 64'd105, 1'b1, 1'b1, a1);
        check("amo_resume_gap", 64'(a1 - a0), 64'd2);
        idle(4);

        // Response backpressure: only two requests fit
        rsp_ready_i = 1'b0;
        issue(32'h20, 4'd0, 1'b0, '0, 8'hFF, 4'd8, 64'h1000, 1'b1, 1'b0, a0);
        issue(32'h21, 4'd0, 1'b0, '0, 8'hFF, 4'd9, 64'h1001, 1'b1, 1'b0, a1);
        check("bp_two_accepts", 64'(a1 - a0), 64'd1);
        req_valid_i = 1'b1; req_addr_i = 32'h22; req_id_i = 4'd10;
        stall_acc = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready_o) stall_acc++;
            @(posedge clk); #1;
        end
        check("bp_stall_accepts", 64'(stall_acc), 64'd0);
        check("bp_rsp_pending", 64'(rsp_valid_o), 64'd1);
        rsp_ready_i = 1'b1;
        rel = cyc;
        issue(32'h22, 4'd0, 1'b0, '0, 8'hFF, 4'd10, 64'h1002, 1'b1, 1'b0, a0);
        check("bp_resume_same_cycle", 64'(a0), 64'(rel));
        issue(32'h23, 4'd0, 1'b0, '0, 8'hFF, 4'd11, 64'h1003, 1'b1, 1'b0, a1);
        idle(4);

        // Store with partial byte enable, then read back
        req_valid_i = 1'b1; req_addr_i = 32'h50; req_amo_i = 4'd0; req_wen_i = 1'b1;
        req_wdata_i = 64'h1122_3344_5566_7788; req_be_i = 8'h0F; req_id_i = 4'd5;
        #1;
        check("store_bank_wen", 64'(bank_wen_o), 64'd1);
        check("store_bank_be", 64'(bank_be_o), 64'h0F);
        check("store_bank_add", 64'(bank_add_o), 64'h50);
        check("store_bank_wdata", bank_wdata_o, 64'h1122_3344_5566_7788);
        issue(32'h50, 4'd0, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, 4'd5, '0, 1'b0, 1'b1, a0);
        issue(32'h50, 4'd0, 1'b0, '0, 8'hFF, 4'd6, 64'h0000_0000_5566_7788, 1'b1, 1'b1, a1);
        idle(4);

        // Reset with one response buffered and one inflight
        rsp_ready_i = 1'b0;
        issue(32'h10, 4'd0, 1'b0, '0, 8'hFF, 4'd12, 64'hDEAD_BEEF, 1'b1, 1'b0, a0);
        issue(32'h20, 4'd0, 1'b0, '0, 8'hFF, 4'd13, 64'h1000, 1'b1, 1'b0, a1);
        req_valid_i = 1'b0;
        check("pre_rst_valid", 64'(rsp_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid_immediate", 64'(rsp_valid_o), 64'd0);
        sb.delete();
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(6);
        check("post_rst_no_rsp", 64'(rsp_valid_o), 64'd0);
        issue(32'h21, 4'd0, 1'b0, '0, 8'hFF, 4'd14, 64'h1001, 1'b1, 1'b1, a0);
        idle(1);

        // Drain
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("end_rsp_valid", 64'(rsp_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcdm_bank_adapter.md
Name: tcdm_bank_adapter

Overview:
- Request/response adapter between the TCDM interconnect (valid/ready with transaction ID) and the per-bank atomic shim in front of a single-port SRAM.
- Converts the shim's req/gnt, fixed one-cycle read latency into a decoupled response channel carrying rdata and ID.
- Uses a credit-checked response FIFO, so the bank is never issued a request whose response cannot be stored.
- Absorbs the grant withdrawal the shim asserts during an AMO commit cycle.

Parameters:
- AddrMemWidth, 32, bank word address width.
- DataWidth, 64, data width; only 32 or 64 is legal.
- IdWidth, 4, transaction ID width.
- RspDepth, 2, response FIFO entries; must be >= 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request accepted.
- req_addr_i  in  AddrMemWidth  word address.
- req_amo_i  in  4  AMO opcode; 0 means plain access.
- req_wen_i  in  1  1 = store, 0 = load.
- req_wdata_i  in  DataWidth  write data / AMO operand.
- req_be_i  in  DataWidth/8  byte enable.
- req_id_i  in  IdWidth  transaction ID.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_rdata_o  out  DataWidth  read data; AMO old value.
- rsp_id_o  out  IdWidth  ID of the responded request.
- bank_req_o  out  1  request to the shim.
- bank_gnt_i  in  1  grant from the shim; may be combinational from bank_req_o.
- bank_add_o  out  AddrMemWidth  address to the shim.
- bank_amo_o  out  4  opcode to the shim.
- bank_wen_o  out  1  write enable to the shim.
- bank_wdata_o  out  DataWidth  write data to the shim.
- bank_be_o  out  DataWidth/8  byte enable to the shim.
- bank_rdata_i  in  DataWidth  shim read data, valid one cycle after a grant.

Behaviour:
- Reset (async, rst_ni low): FIFO count = 0, pointers = 0, inflight_q = 0, inflight_id_q = 0, rsp_valid_o = 0. Reset mid-transaction drops any inflight or buffered responses; no response is produced for them.
- Credit: pop = rsp_valid_o & rsp_ready_i. credit_ok = (count + inflight_q - pop) < RspDepth. The rsp_ready_i to req_ready_o combinational path is intentional.
- bank_req_o = req_valid_i & credit_ok. bank_add/amo/wen/wdata/be_o pass through from the req_* inputs unregistered.
- req_ready_o = bank_gnt_i & credit_ok.
- Handshake (accept) = req_valid_i & req_ready_o. Upstream keeps the request stable while valid and not ready. The bank holding gnt low (AMO commit) stalls acceptance only.
- On accept in cycle t: inflight_q <= 1 and inflight_id_q <= req_id_i; otherwise inflight_q <= 0.
- In cycle t+1, when inflight_q = 1: push {bank_rdata_i, inflight_id_q} into the FIFO. Every request returns exactly one response; stores return rdata = bank_rdata_i, which is don't-care.
- AMO: accepted at t. The shim commits at t+1 with gnt = 0 and drives the old value on bank_rdata_i, which is captured at t+1. Back-to-back requests resume acceptance at t+2.
- FIFO: circular buffer, pointers wrap at RspDepth. rsp_valid_o = count != 0. Push and pop in the same cycle leaves count unchanged.
- Push while full is impossible by construction; the bench checks it by assertion. Pop while empty cannot occur.
- Response latency, accept to rsp_valid_o: 2 cycles.
- Throughput: 1 request per cycle sustained with RspDepth = 2 and rsp_ready_i held high.
- Responses are returned strictly in order.

Optional Feature:
- Macro TCDM_BANK_ADAPTER_BYPASS_EN.
- Defined: when count == 0 and inflight_q = 1, rsp_valid_o = 1 in cycle t+1, driving bank_rdata_i and inflight_id_q directly. If rsp_ready_i = 1 the entry is not pushed; otherwise it is pushed normally. Latency becomes 1 cycle. Credit equation unchanged, with pop including the bypass pop.
- Undefined: all responses pass through the FIFO; latency is 2 cycles.

Test Plan:
- Single load, addr 0x10, id 3, bank_rdata 0xDEAD_BEEF at t+1 -> rsp_valid_o at t+2 (t+1 with bypass), rdata 0xDEAD_BEEF, id 3; req_ready_o = 1 at t.
- 8 back-to-back loads, ids 0..7, rsp_ready_i = 1 -> 8 accepts in 8 consecutive cycles; responses in order, ids 0..7, no gaps.
- AMO add (req_amo_i = 2) at t followed by a load; the shim model holds gnt = 0 at t+1 -> load accepted at t+2; AMO response carries the old value, load response carries the post-AMO value.
- rsp_ready_i = 0, 4 loads offered, RspDepth = 2 -> exactly 2 accepted, req_ready_o = 0 afterwards, no FIFO overflow. Raising rsp_ready_i drains ids in order and acceptance resumes in the same cycle as the first pop.
- Store with be = 0x0F, id 5 -> bank_wen_o = 1 and bank_be_o = 0x0F passed through; one response with id 5 returned.
- rst_ni pulsed low while 1 request is inflight and 1 is buffered -> rsp_valid_o = 0 immediately; no stale responses after reset; the next request completes normally.
